// File: rtl/cfgtag_raw_rx_if.sv
// Handshake bundle between gateway, receive buffer and local consumer.
// slave = buffer side, master = gateway/consumer side.
interface cfgtag_raw_rx_if #(
    parameter int width_p = 32
);
    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               credit_o;
    logic               valid_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    modport slave (
        input  valid_i, data_i, yumi_i,
        output credit_o, valid_o, data_o
    );

    modport master (
        output valid_i, data_i, yumi_i,
        input  credit_o, valid_o, data_o
    );
endinterface

// File: rtl/cfgtag_raw_rx.sv
// Credit-based receive FIFO for the config-tag gateway raw side.
// One credit pulse per freed entry; overflow drops and sets a sticky flag.
module cfgtag_raw_rx #(
    parameter int els_p   = 4,
    parameter int width_p = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    cfgtag_raw_rx_if.slave             bus,
    output logic [$clog2(els_p+1)-1:0] count_o,
    output logic                       overflow_o
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p+1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic [cnt_w-1:0]   cnt;
    logic               credit_r;
    logic               ovf_r;

    logic empty;
    logic full;
    logic deq;
    logic enq;
    logic drop;

    assign empty = (cnt == '0);
    assign full  = (cnt == cnt_w'(els_p));
    assign deq   = bus.yumi_i & ~empty;
    // A full buffer still takes a word when the head leaves this cycle.
    assign enq   = bus.valid_i & (~full | deq);
    assign drop  = bus.valid_i & full & ~deq;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            credit_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (enq)
                wptr <= wptr + 1'b1;
            if (deq)
                rptr <= rptr + 1'b1;
            cnt      <= cnt + cnt_w'(enq) - cnt_w'(deq);
            credit_r <= deq;
            if (drop)
                ovf_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq & ~reset)
            mem[wptr] <= bus.data_i;
    end

    assign bus.valid_o  = ~empty;
    assign bus.data_o   = mem[rptr];
    assign bus.credit_o = credit_r;
    assign count_o      = cnt;
    assign overflow_o   = ovf_r;
endmodule
